// File: rtl/readpixel.sv
// -----------------------------------------------------------------------------
// readpixel
//
// Receive-side decoder for a single-wire WS2812-style pixel stream. The line is
// synchronised to clk and each high pulse is measured in clock cycles. The
// first 24 bits of a frame (G, R, B, MSB first) are assembled into a pixel.
// All later bits in the same frame are passed through on d_out, as a physical
// pixel in a daisy chain would do. A low period of latch_cycles ends the frame.
//
// Parameters
//   clk_in_rate_hz     system clock rate (informational only; all thresholds
//                      are expressed in cycles)
//   min_high_cycles    high pulses shorter than this are glitches
//   one_thresh_cycles  high pulses at least this long decode as 1
//   latch_cycles       low time that ends a frame; also the stuck-high limit
//
// Ports
//   clk                       system clock, rising edge
//   rst_n                     asynchronous active-low reset
//   d_in                      serial pixel line (asynchronous to clk)
//   pixel_r/pixel_g/pixel_b   last decoded pixel, held until the next valid
//   valid                     one-cycle pulse when a new pixel is loaded
//   d_out                     pass-through of the bits after the first 24
//   busy                      a frame is in progress
//   latch                     one-cycle pulse on end-of-frame low time
//   error                     one-cycle pulse on glitch, stuck-high or
//                             partial pixel
// -----------------------------------------------------------------------------
module readpixel #(
    parameter int clk_in_rate_hz    = 12_000_000,
    parameter int min_high_cycles   = 2,
    parameter int one_thresh_cycles = 8,
    parameter int latch_cycles      = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_in,
    output logic [7:0] pixel_r,
    output logic [7:0] pixel_g,
    output logic [7:0] pixel_b,
    output logic       valid,
    output logic       d_out,
    output logic       busy,
    output logic       latch,
    output logic       error
);

    // Reject parameter sets where the thresholds cannot be ordered sensibly.
    if (clk_in_rate_hz <= 0 || min_high_cycles < 1 ||
        one_thresh_cycles <= min_high_cycles ||
        latch_cycles <= one_thresh_cycles) begin : g_bad_params
        $error("readpixel: inconsistent timing parameters");
    end

    localparam int CW = $clog2(latch_cycles + 1);
    localparam logic [CW-1:0] C_LATCH = CW'(latch_cycles);
    localparam logic [CW-1:0] C_MIN   = CW'(min_high_cycles);
    localparam logic [CW-1:0] C_ONE   = CW'(one_thresh_cycles);

    typedef enum logic [2:0] {
        ST_RESYNC  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_HIGH    = 3'd2,
        ST_LOW     = 3'd3,
        ST_FORWARD = 3'd4
    } state_t;

    // Input synchroniser and edge-detect delay
    logic r_sync1;
    logic r_d_s;
    logic r_d_s_q;

    logic [CW-1:0] r_high_cnt;
    logic [CW-1:0] r_low_cnt;
    logic [4:0]    r_bit_cnt;
    logic [23:0]   r_shift;
    state_t        r_state;

    logic [7:0] r_pixel_r;
    logic [7:0] r_pixel_g;
    logic [7:0] r_pixel_b;
    logic       r_valid;
    logic       r_busy;
    logic       r_latch;
    logic       r_error;

    logic        w_rise;
    logic        w_fall;
    logic        w_bit;
    logic [23:0] w_shift_next;

    assign w_rise       = r_d_s & ~r_d_s_q;
    assign w_fall       = ~r_d_s & r_d_s_q;
    assign w_bit        = (r_high_cnt >= C_ONE);
    assign w_shift_next = {r_shift[22:0], w_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_d_s   <= 1'b0;
            r_d_s_q <= 1'b0;
        end else begin
            r_sync1 <= d_in;
            r_d_s   <= r_sync1;
            r_d_s_q <= r_d_s;
        end
    end

    // Each counter holds the length of the current run of its level. The
    // register still holds the finished run length during the edge cycle,
    // which is when the FSM inspects it, and clears on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_cnt <= '0;
            r_low_cnt  <= '0;
        end else begin
            if (w_fall) begin
                r_high_cnt <= '0;
            end else if (r_d_s && r_high_cnt != C_LATCH) begin
                r_high_cnt <= r_high_cnt + 1'b1;
            end

            if (w_rise) begin
                r_low_cnt <= '0;
            end else if (!r_d_s && r_low_cnt != C_LATCH) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RESYNC;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_pixel_r <= '0;
            r_pixel_g <= '0;
            r_pixel_b <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_latch   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_latch <= 1'b0;
            r_error <= 1'b0;

            case (r_state)
                // Wait for a full latch period so decoding never starts
                // in the middle of someone else's frame.
                ST_RESYNC: begin
                    if (r_low_cnt == C_LATCH) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (w_rise) begin
                        r_state   <= ST_HIGH;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                    end
                end

                ST_HIGH: begin
                    // Stuck-high takes priority so a saturated count is never
                    // decoded as a data bit.
                    if (r_high_cnt == C_LATCH) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_RESYNC;
                    end else if (w_fall) begin
                        if (r_high_cnt < C_MIN) begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_RESYNC;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == 5'd23) begin
                                r_pixel_g <= w_shift_next[23:16];
                                r_pixel_r <= w_shift_next[15:8];
                                r_pixel_b <= w_shift_next[7:0];
                                r_valid   <= 1'b1;
                                r_state   <= ST_FORWARD;
                            end else begin
                                r_state <= ST_LOW;
                            end
                        end
                    end
                end

                ST_LOW: begin
                    // Latch time reached before 24 bits: partial pixel.
                    if (r_low_cnt == C_LATCH) begin
                        r_latch <= 1'b1;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_rise) begin
                        r_state <= ST_HIGH;
                    end
                end

                ST_FORWARD: begin
                    if (r_low_cnt == C_LATCH) begin
                        r_latch <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_RESYNC;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pass-through taps the synchronised line directly so downstream pixels
    // see the original pulse widths with only the synchroniser delay.
    assign d_out   = (r_state == ST_FORWARD) & r_d_s;

    assign pixel_r = r_pixel_r;
    assign pixel_g = r_pixel_g;
    assign pixel_b = r_pixel_b;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign latch   = r_latch;
    assign error   = r_error;

endmodule

// File: tb/tb_readpixel.sv
`timescale 1ns/1ps
module tb_readpixel;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       d_in  = 1'b0;
    logic [7:0] pixel_r;
    logic [7:0] pixel_g;
    logic [7:0] pixel_b;
    logic       valid;
    logic       d_out;
    logic       busy;
    logic       latch;
    logic       error;

    readpixel dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_in    (d_in),
        .pixel_r (pixel_r),
        .pixel_g (pixel_g),
        .pixel_b (pixel_b),
        .valid   (valid),
        .d_out   (d_out),
        .busy    (busy),
        .latch   (latch),
        .error   (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          v;
        bit          l;
        bit          e;
        logic [23:0] px;
        int          at;
    } ev_t;

    typedef struct {
        int at;
        int w;
    } pl_t;

    typedef struct {
        bit up;
        int at;
    } bz_t;

    ev_t ev_q[$];
    pl_t do_q[$];
    bz_t bz_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame-level rules of the pixel protocol.
    // Times are in clk cycles; pr / pf are the first rising clock edges
    // after d_in goes high / low.
    // ------------------------------------------------------------------
    bit          m_sync = 1'b0;
    int          m_nb   = -1;     // bits decoded in current frame, -1 = no frame
    bit          m_fwd  = 1'b0;
    logic [23:0] m_sh   = '0;
    logic [23:0] m_last = '0;

    task automatic push_ev(bit v, bit l, bit e, logic [23:0] px, int at);
        ev_t x;
        x.v = v; x.l = l; x.e = e; x.px = px; x.at = at;
        ev_q.push_back(x);
    endtask

    task automatic push_bz(bit up, int at);
        bz_t x;
        x.up = up; x.at = at;
        bz_q.push_back(x);
    endtask

    task automatic push_do(int at, int w);
        pl_t x;
        x.at = at; x.w = w;
        do_q.push_back(x);
    endtask

    task automatic model(int pr, int hi, int lo);
        int pf;
        pf = pr + hi;
        if (!m_sync) begin
            // ignored until a full latch-length low period is seen
            if (lo >= 600) m_sync = 1'b1;
            return;
        end
        if (m_nb < 0) begin
            push_bz(1'b1, pr + 2);
            m_nb  = 0;
            m_fwd = 1'b0;
        end
        if (m_fwd) begin
            push_do(pr + 1, hi);
        end else if (hi >= 600) begin
            push_ev(1'b0, 1'b0, 1'b1, 24'h0, pr + 602);
            push_bz(1'b0, pr + 602);
            m_nb   = -1;
            m_sync = (lo >= 600);
            return;
        end else if (hi < 2) begin
            push_ev(1'b0, 1'b0, 1'b1, 24'h0, pf + 2);
            push_bz(1'b0, pf + 2);
            m_nb   = -1;
            m_sync = (lo >= 600);
            return;
        end else begin
            m_sh = {m_sh[22:0], (hi >= 8) ? 1'b1 : 1'b0};
            m_nb++;
            if (m_nb == 24) begin
                m_fwd  = 1'b1;
                m_last = m_sh;
                push_ev(1'b1, 1'b0, 1'b0, m_sh, pf + 2);
            end
        end
        if (lo >= 600) begin
            push_ev(1'b0, 1'b1, !m_fwd, 24'h0, pf + 602);
            push_bz(1'b0, pf + 602);
            m_nb  = -1;
            m_fwd = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (always called and returning at a falling clk edge)
    // ------------------------------------------------------------------
    task automatic pulse(int hi, int lo);
        model(cyc + 1, hi, lo);
        d_in = 1'b1;
        repeat (hi) @(negedge clk);
        d_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // mode 0: writer timing; 1: random widths; 2: zeros of 2/7, ones of 8
    function automatic int hi_w(bit b, int mode, int i);
        case (mode)
            0:       return b ? 12 : 4;
            1:       return b ? int'($urandom_range(20, 8)) : int'($urandom_range(7, 2));
            default: return b ? 8 : ((i % 2) ? 7 : 2);
        endcase
    endfunction

    function automatic int lo_w(bit b, int mode);
        if (mode == 0) return b ? 4 : 12;
        return int'($urandom_range(14, 2));
    endfunction

    task automatic send_bits(logic [63:0] bits, int n, int mode, int last_lo);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = bits[n - 1 - i];
            pulse(hi_w(b, mode, i), (i == n - 1) ? last_lo : lo_w(b, mode));
        end
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_pixel"}, {pixel_g, pixel_r, pixel_b}, 24'h0);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_latch"}, latch, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_busy"},  busy,  1'b0);
        check({tag, "_d_out"}, d_out, 1'b0);
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_cleared("midrst");
        m_sync = 1'b0;
        m_nb   = -1;
        m_fwd  = 1'b0;
        m_last = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        bit  pb;
        bit  pd;
        int  ds;
        ev_t e;
        pl_t p;
        bz_t b;
        pb = 1'b0; pd = 1'b0; ds = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 1'b0;
                pd = 1'b0;
                continue;
            end
            if (valid || latch || error) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_event", {valid, latch, error}, 3'b000);
                end else begin
                    e = ev_q.pop_front();
                    $display("event v=%0b l=%0b e=%0b px=%06h at cycle %0d", valid, latch, error,
                             {pixel_g, pixel_r, pixel_b}, cyc);
                    check("event_cycle", cyc, e.at);
                    check("event_flags", {valid, latch, error}, {e.v, e.l, e.e});
                    if (e.v) check("pixel", {pixel_g, pixel_r, pixel_b}, e.px);
                end
            end
            if (busy !== pb) begin
                if (bz_q.size() == 0) begin
                    check("unexpected_busy_edge", busy, pb);
                end else begin
                    b = bz_q.pop_front();
                    check("busy_edge_dir", busy, b.up);
                    check("busy_edge_cycle", cyc, b.at);
                end
                pb = busy;
            end
            if (d_out && !pd) ds = cyc;
            if (!d_out && pd) begin
                if (do_q.size() == 0) begin
                    check("unexpected_d_out_pulse", ds, -1);
                end else begin
                    p = do_q.pop_front();
                    $display("d_out pulse start %0d width %0d", ds, cyc - ds);
                    check("d_out_start", ds, p.at);
                    check("d_out_width", cyc - ds, p.w);
                end
            end
            pd = d_out;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err + 1);
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int n;
        int mode;
        int k;
        logic [63:0] bits;

        #12 check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (650) @(negedge clk);
        m_sync = 1'b1;

        // single pixel at writer timing
        send_bits(64'hA53C0F, 24, 0, 650);

        // two pixels back-to-back, second one forwarded
        send_bits({40'h0, 24'h112233} << 24 | 64'hFFFFFF, 48, 0, 650);

        // threshold widths 2/7 decode as 0, 8 as 1
        send_bits(64'h96A55A, 24, 2, 650);

        // 1-cycle glitch from idle, and mid-frame
        pulse(1, 650);
        send_bits(64'h5, 3, 0, 6);
        pulse(1, 650);

        // partial frame then a full pixel
        send_bits(64'h2B5, 10, 0, 650);
        send_bits(64'h808080, 24, 0, 650);

        // stuck high; pulses during the short low after it are ignored
        pulse(700, 300);
        send_bits(64'hFFF, 12, 0, 650);
        send_bits(64'h123456, 24, 0, 650);

        // reset in the middle of a frame
        send_bits(64'hC0F, 12, 0, 5);
        mid_reset();
        send_bits(64'hFEE, 12, 0, 650);
        send_bits(64'h5AA55A, 24, 0, 650);

        // randomized frames
        for (int f = 0; f < 16; f++) begin
            bits = {$urandom, $urandom};
            mode = int'($urandom_range(1, 0));
            case ($urandom_range(3, 0))
                0:       n = 24;
                1:       n = int'($urandom_range(23, 1));
                default: n = 24 + int'($urandom_range(24, 1));
            endcase
            if ($urandom_range(7, 0) == 0) begin
                k = int'($urandom_range(10, 0));
                if (k > 0) send_bits(bits, k, mode, 5);
                pulse(1, 650);
            end else begin
                send_bits(bits, n, mode, 650);
            end
        end

        repeat (20) @(negedge clk);
        check("final_pixel", {pixel_g, pixel_r, pixel_b}, m_last);
        check("final_busy", busy, 1'b0);
        check("pending_events", ev_q.size(), 0);
        check("pending_busy_edges", bz_q.size(), 0);
        check("pending_d_out_pulses", do_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
